// File: rtl/snake_pkg.sv
// Shared direction encodings and small helpers for the snake direction controller.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    // Two directions are opposite exactly when they differ only in bit 1.
    localparam dir_t DIR_OPPOSITE = 2'b10;

    // A turn is legal only if it neither repeats nor reverses the reference.
    function automatic logic turn_ok(input dir_t cand, input dir_t ref_dir);
        return (cand != ref_dir) && ((cand ^ ref_dir) != DIR_OPPOSITE);
    endfunction

    // Fixed priority among simultaneous presses: up > right > down > left.
    function automatic dir_t pick_dir(input logic up, input logic right,
                                      input logic down, input logic left);
        dir_t d;
        d = DIR_LEFT;
        if (down)  d = DIR_DOWN;
        if (right) d = DIR_RIGHT;
        if (up)    d = DIR_UP;
        // left is the fallback when nothing higher is pressed
        if (!(up || right || down) && !left) d = DIR_LEFT;
        return d;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press
);

    logic prev;

    // Track last-cycle level; reset high so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= level;
    end

    assign press = level & ~prev;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: buffers validated turns and applies one per game tick.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] START_DIR   = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_center,
    output logic [1:0] dir,
    output logic       turn_pulse,
    output logic       paused,
    output logic [2:0] queue_count
);

    localparam int            PW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [2:0]    DEPTH_C  = 3'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(QUEUE_DEPTH - 1);

    // Bit order: 0 up, 1 right, 2 down, 3 left, 4 center.
    logic [4:0] levels;
    logic [4:0] press;

    assign levels = {btn_center, btn_left, btn_down, btn_right, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_edge
        btn_edge u_edge (
            .clk   (clk),
            .reset (reset),
            .level (levels[i]),
            .press (press[i])
        );
    end

    // Circular turn buffer; tail points at the next free slot.
    dir_t          queue_buf [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    logic          pop;
    logic          push;
    logic          enter_pause;
    dir_t          dir_after;
    dir_t          ref_dir;
    dir_t          cand;
    logic [2:0]    count_after_pop;
    logic [PW-1:0] tail_last;

    // Decide this cycle's pop and whether the winning press may be enqueued behind it.
    always_comb begin
        pop             = tick && !paused && (queue_count != 3'd0);
        dir_after       = pop ? queue_buf[head] : dir;
        count_after_pop = queue_count - {2'b00, pop};
        tail_last       = (tail == '0) ? LAST_IDX : tail - 1'b1;
        ref_dir         = (count_after_pop != 3'd0) ? queue_buf[tail_last] : dir_after;
        cand            = pick_dir(press[0], press[1], press[2], press[3]);
        enter_pause     = press[4] && !paused;
        push            = (|press[3:0]) && !paused && !press[4] &&
                          turn_ok(cand, ref_dir) &&
                          ((queue_count != DEPTH_C) || pop);
    end

    // Direction, pause and queue state; a pause entry flushes any pending turns.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir         <= START_DIR;
            turn_pulse  <= 1'b0;
            paused      <= 1'b0;
            queue_count <= 3'd0;
            head        <= '0;
            tail        <= '0;
        end else begin
            turn_pulse <= pop;
            if (pop)      dir    <= queue_buf[head];
            if (press[4]) paused <= ~paused;
            if (enter_pause) begin
                queue_count <= 3'd0;
                head        <= '0;
                tail        <= '0;
            end else begin
                if (pop) head <= ptr_inc(head);
                if (push) begin
                    queue_buf[tail] <= cand;
                    tail            <= ptr_inc(tail);
                end
                queue_count <= count_after_pop + {2'b00, push};
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with a queue of expected turns.
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick;
    logic       btn_up, btn_right, btn_down, btn_left, btn_center;
    logic [1:0] dir;
    logic       turn_pulse, paused;
    logic [2:0] queue_count;

    int   checks = 0;
    int   errors = 0;
    dir_t exp_q[$];
    dir_t exp_d;

    always #5 clk = ~clk;

    snake_dir_ctrl #(.QUEUE_DEPTH(2), .START_DIR(2'b01)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .btn_up      (btn_up),
        .btn_right   (btn_right),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_center  (btn_center),
        .dir         (dir),
        .turn_pulse  (turn_pulse),
        .paused      (paused),
        .queue_count (queue_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic u, input logic r, input logic d,
                         input logic l, input logic c, input logic t);
        btn_up = u; btn_right = r; btn_down = d; btn_left = l;
        btn_center = c; tick = t;
    endtask

    // One-cycle press followed by an idle cycle so the next press sees a fresh edge.
    task automatic press(input logic u, input logic r, input logic d,
                         input logic l, input logic c);
        drive(u, r, d, l, c, 1'b0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 1);
        cyc(); cyc();
        checks++; if (dir !== 2'b01) begin errors++; $display("FAIL reset_dir got %0d expected 1", dir); end
        checks++; if (turn_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %0b expected 0", turn_pulse); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %0b expected 0", paused); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", queue_count); end
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL held_up_count cycle %0d got %0d expected 0", i, queue_count); end
        end
        checks++; if (dir !== DIR_RIGHT) begin errors++; $display("FAIL held_up_dir got %0d expected 1", dir); end
        drive(0, 0, 0, 0, 0, 0);
        cyc();
    endtask

    task automatic test_turns();
        press(1, 0, 0, 0, 0); exp_q.push_back(DIR_UP);
        checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL turns_count1 got %0d expected 1", queue_count); end
        press(0, 0, 0, 1, 0); exp_q.push_back(DIR_LEFT);
        checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL turns_count2 got %0d expected 2", queue_count); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0);
            exp_d = exp_q.pop_front();
            checks++; if (dir !== exp_d) begin errors++; $display("FAIL turns_dir%0d got %0d expected %0d", i, dir, exp_d); end
            checks++; if (turn_pulse !== 1'b1) begin errors++; $display("FAIL turns_pulse%0d got %0b expected 1", i, turn_pulse); end
            checks++; if (queue_count !== 3'(exp_q.size())) begin errors++; $display("FAIL turns_count_pop%0d got %0d expected %0d", i, queue_count, exp_q.size()); end
            cyc();
            checks++; if (turn_pulse !== 1'b0) begin errors++; $display("FAIL turns_pulse_clear%0d got %0b expected 0", i, turn_pulse); end
        end
    endtask

    task automatic test_reject();
        // Steer back from left to right via up.
        press(1, 0, 0, 0, 0); exp_q.push_back(DIR_UP);
        drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0); cyc();
        exp_d = exp_q.pop_front();
        checks++; if (dir !== exp_d) begin errors++; $display("FAIL reject_setup_up got %0d expected %0d", dir, exp_d); end
        press(0, 1, 0, 0, 0); exp_q.push_back(DIR_RIGHT);
        drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0); cyc();
        exp_d = exp_q.pop_front();
        checks++; if (dir !== exp_d) begin errors++; $display("FAIL reject_setup_right got %0d expected %0d", dir, exp_d); end
        press(0, 0, 0, 1, 0);
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reject_opposite got %0d expected 0", queue_count); end
        press(0, 1, 0, 0, 0);
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reject_same got %0d expected 0", queue_count); end
        drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0);
        checks++; if (dir !== DIR_RIGHT) begin errors++; $display("FAIL reject_tick_dir got %0d expected 1", dir); end
        checks++; if (turn_pulse !== 1'b0) begin errors++; $display("FAIL reject_tick_pulse got %0b expected 0", turn_pulse); end
        cyc();
    endtask

    task automatic test_queue_full();
        press(1, 0, 0, 0, 0); exp_q.push_back(DIR_UP);
        press(0, 0, 0, 1, 0); exp_q.push_back(DIR_LEFT);
        press(0, 0, 1, 0, 0);
        checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL full_no_pop got %0d expected 2", queue_count); end
        drive(0, 0, 1, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0);
        exp_d = exp_q.pop_front(); exp_q.push_back(DIR_DOWN);
        checks++; if (dir !== exp_d) begin errors++; $display("FAIL full_pop_dir got %0d expected %0d", dir, exp_d); end
        checks++; if (turn_pulse !== 1'b1) begin errors++; $display("FAIL full_pop_pulse got %0b expected 1", turn_pulse); end
        checks++; if (queue_count !== 3'd2) begin errors++; $display("FAIL full_pop_push_count got %0d expected 2", queue_count); end
        cyc();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0); cyc();
            exp_d = exp_q.pop_front();
            checks++; if (dir !== exp_d) begin errors++; $display("FAIL full_drain%0d got %0d expected %0d", i, dir, exp_d); end
        end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d expected 0", queue_count); end
    endtask

    task automatic test_pause();
        press(0, 1, 0, 0, 0); exp_q.push_back(DIR_RIGHT);
        checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL pause_pre_count got %0d expected 1", queue_count); end
        press(0, 0, 0, 0, 1); exp_q.delete();
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_enter got %0b expected 1", paused); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL pause_flush got %0d expected 0", queue_count); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0);
            checks++; if (dir !== DIR_DOWN || turn_pulse !== 1'b0) begin errors++; $display("FAIL pause_tick%0d got dir %0d pulse %0b expected dir 2 pulse 0", i, dir, turn_pulse); end
            cyc();
        end
        press(1, 0, 0, 0, 0);
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL pause_press_discard got %0d expected 0", queue_count); end
        press(0, 1, 0, 0, 1);
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_exit got %0b expected 0", paused); end
        checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL pause_center_same_cycle got %0d expected 0", queue_count); end
    endtask

    task automatic test_priority();
        press(0, 1, 0, 0, 0); exp_q.push_back(DIR_RIGHT);
        drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0); cyc();
        exp_d = exp_q.pop_front();
        checks++; if (dir !== exp_d) begin errors++; $display("FAIL prio_setup got %0d expected %0d", dir, exp_d); end
        press(1, 1, 0, 0, 0); exp_q.push_back(DIR_UP);
        checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL prio_count got %0d expected 1", queue_count); end
        drive(0, 0, 0, 0, 0, 1); cyc(); drive(0, 0, 0, 0, 0, 0); cyc();
        exp_d = exp_q.pop_front();
        checks++; if (dir !== exp_d) begin errors++; $display("FAIL prio_head got %0d expected %0d", dir, exp_d); end
    endtask

    task automatic test_reset_mid();
        press(0, 1, 0, 0, 0); exp_q.push_back(DIR_RIGHT);
        checks++; if (queue_count !== 3'd1) begin errors++; $display("FAIL midrst_pre got %0d expected 1", queue_count); end
        reset = 1'b1; drive(0, 0, 0, 0, 0, 1); cyc();
        checks++; if (dir !== 2'b01 || queue_count !== 3'd0 || turn_pulse !== 1'b0) begin errors++; $display("FAIL midrst got dir %0d count %0d pulse %0b expected 1 0 0", dir, queue_count, turn_pulse); end
        reset = 1'b0; drive(0, 0, 0, 0, 0, 0); exp_q.delete(); cyc();
    endtask

    initial begin
        test_reset();
        test_turns();
        test_reject();
        test_queue_full();
        test_pause();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2, number of buffered pending turns (supported values 1..4).
REQ-002 Parameter START_DIR, default 2'b01, snake direction after reset.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 tick  input  1  one-cycle game-step strobe from the game timer.
REQ-006 btn_up, btn_right, btn_down, btn_left  input  1 each  debounced button levels, high = pressed.
REQ-007 btn_center  input  1  debounced pause button level, high = pressed.
REQ-008 dir  output  2  current direction: 00 up, 01 right, 10 down, 11 left.
REQ-009 turn_pulse  output  1  high for one cycle when dir changes.
REQ-010 paused  output  1  high while the game is paused.
REQ-011 queue_count  output  3  number of pending turns, 0..QUEUE_DEPTH.

Function
REQ-012 Press detection SHALL be a rising edge per button: press = level AND NOT previous-cycle level.
REQ-013 Multiple direction presses in one cycle SHALL resolve by priority up > right > down > left, and only the winner SHALL be considered.
REQ-014 Reference direction for enqueue SHALL be the queue tail entry when the post-pop count is >0, else the post-tick dir.
REQ-015 A candidate SHALL be rejected if equal to the reference or its opposite (candidate XOR reference == 2'b10).
REQ-016 A candidate SHALL be rejected when the queue is full, unless a pop occurs in the same cycle.
REQ-017 An accepted candidate SHALL appear in queue_count on the next cycle (1-cycle latency).
REQ-018 On tick with paused=0 and queue_count>0: dir SHALL take the head entry, the head SHALL pop, and turn_pulse SHALL be 1 on the next cycle only.
REQ-019 On tick with an empty queue, or with paused=1: dir and queue SHALL be unchanged and turn_pulse SHALL stay 0.
REQ-020 A tick and a press in the same cycle SHALL both take effect: pop first, then enqueue validated per REQ-014.
REQ-021 A btn_center press SHALL toggle paused on the next cycle.
REQ-022 Entering pause SHALL flush the queue to 0.
REQ-023 Direction presses while paused=1, or in the same cycle as a center press, SHALL be discarded.
REQ-024 Queue pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-025 queue_count SHALL never exceed QUEUE_DEPTH or underflow below 0.

Reset
REQ-026 While reset=1: dir=START_DIR, turn_pulse=0, paused=0, queue_count=0, and pointers=0.
REQ-027 Previous-level registers SHALL reset to 1, so buttons held through reset generate no press.
REQ-028 Reset asserted mid-operation SHALL override tick and presses in the same cycle.

Structure
REQ-029 Package snake_pkg SHALL hold the direction encodings (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT), a 2-bit direction typedef, and the opposite-direction constant 2'b10.
REQ-030 Rising-edge detection SHALL be one sub-module btn_edge, instantiated five times.
REQ-031 The queue SHALL be implemented inline as a small circular buffer with head/tail pointers and a count.

Verification
REQ-032 Reset with btn_up held, release reset, hold btn_up 5 cycles -> queue_count stays 0 and dir=01.
REQ-033 From dir=01: press up, then press left, then tick, tick -> queue_count 1 then 2; dir=00 with turn_pulse, then dir=11 with turn_pulse.
REQ-034 From dir=01: press left (opposite) and press right (same) -> both rejected, queue_count=0, dir=01 after tick.
REQ-035 Queue full (up, left queued) plus a third press down coinciding with a tick -> pop up, accept down, queue_count=2, dir=00.
REQ-036 Queue holds 1 entry, press center -> paused=1, queue_count=0; ticks leave dir unchanged; press center -> paused=0.
REQ-037 Press up and right in the same cycle -> only up is enqueued (queue_count=1, head=00).
